// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision normalize/round stage.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int BIAS       = 127;
    localparam int EXP_INF    = 255;
    localparam int MANT_W     = 23;
    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int GUARD_BIT  = 2;
    localparam int MAX_LSHIFT = 26;

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Operand/result handshake bundle between the add/sub core and the normalize/round stage.
interface fp_norm_round_if #(
    parameter int EXP_W  = 10,
    parameter int FRAC_W = 28
);
    // Each side transfers on the rising edge where valid & ready are both high;
    // the producer holds valid and its data stable until that edge.
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_overflow;
    logic              out_underflow;
    logic              out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_frac, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );
endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and IEEE-754 single packing with saturation/flush.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic                sign,
    input  logic [EXP_W-1:0]    exp,
    input  logic [HIDDEN_BIT:0] frac,
    output fp32_t               result,
    output logic                overflow,
    output logic                underflow,
    output logic                inexact
);
    logic              lsb;
    logic              g;
    logic              rs;
    logic              inc;
    logic [MANT_W+1:0] sum;
    logic [EXP_W:0]    exp_r;

    always_comb begin
        lsb   = frac[GUARD_BIT+1];
        g     = frac[GUARD_BIT];
        rs    = |frac[GUARD_BIT-1:0];
        inc   = g & (rs | lsb);
        sum   = {1'b0, frac[HIDDEN_BIT:GUARD_BIT+1]} + (MANT_W+2)'(inc);
        // A carry out of the mantissa leaves sum[MANT_W-1:0] at zero already.
        exp_r = {exp[EXP_W-1], exp} + (EXP_W+1)'(sum[MANT_W+1]);

        result    = '{sign: sign, exp: exp_r[7:0], mant: sum[MANT_W-1:0]};
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = g | rs;

        if (frac == '0) begin
            result  = '{sign: sign, exp: 8'h00, mant: '0};
            inexact = 1'b0;
        end else if (exp_r[EXP_W] || exp_r == '0) begin
            result    = '{sign: sign, exp: 8'h00, mant: '0};
            underflow = 1'b1;
        end else if (exp_r >= (EXP_W+1)'(EXP_INF)) begin
            result   = '{sign: sign, exp: 8'(EXP_INF), mant: '0};
            overflow = 1'b1;
            inexact  = 1'b1;
        end
    end
endmodule

// File: rtl/fp_norm_round.sv
// Normalize/round stage of the single-precision add/sub datapath, one operation in flight.
// FP_NORM_FAST_EN: single-cycle leading-one normalization instead of 1 bit per cycle.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int FRAC_W = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_norm_round_if.slave        bus,
    output state_t                dbg_state
);
    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic              zero_q, zero_d;
    fp32_t             result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              inx_q, inx_d;

    fp32_t             rnd_result;
    logic              rnd_ovf;
    logic              rnd_unf;
    logic              rnd_inx;

`ifdef FP_NORM_FAST_EN
    logic [4:0]        lz;

    always_comb begin
        lz = 5'd0;
        // Ascending scan: the highest set bit writes last and wins.
        for (int i = 0; i <= HIDDEN_BIT; i++) begin
            if (frac_q[i]) lz = 5'(HIDDEN_BIT - i);
        end
    end
`else
    logic [4:0]        cnt_q, cnt_d;
`endif

    fp_round_rne #(.EXP_W(EXP_W)) u_round (
        .sign      (sign_q),
        .exp       (exp_q),
        .frac      (frac_q[HIDDEN_BIT:0]),
        .result    (rnd_result),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf),
        .inexact   (rnd_inx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            zero_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
`ifndef FP_NORM_FAST_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
`ifndef FP_NORM_FAST_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        zero_d   = zero_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
`ifndef FP_NORM_FAST_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = bus.in_exp;
                    frac_d  = bus.in_frac;
                    zero_d  = (bus.in_frac == '0);
                    state_d = NORM;
`ifndef FP_NORM_FAST_EN
                    cnt_d   = '0;
`endif
                end
            end
            NORM: begin
`ifdef FP_NORM_FAST_EN
                state_d = ROUND;
                if (zero_q) begin
                    state_d = ROUND;
                end else if (frac_q[CARRY_BIT]) begin
                    frac_d = {1'b0, frac_q[FRAC_W-1:2], frac_q[1] | frac_q[0]};
                    exp_d  = exp_q + EXP_W'(1);
                end else begin
                    frac_d = frac_q << lz;
                    exp_d  = exp_q - EXP_W'(lz);
                end
`else
                if (zero_q) begin
                    state_d = ROUND;
                end else if (frac_q[CARRY_BIT]) begin
                    // Shifted-out bit folds into sticky so rounding still sees it.
                    frac_d = {1'b0, frac_q[FRAC_W-1:2], frac_q[1] | frac_q[0]};
                    exp_d  = exp_q + EXP_W'(1);
                end else if (!frac_q[HIDDEN_BIT]) begin
                    if (cnt_q == 5'(MAX_LSHIFT)) begin
                        state_d = ROUND;
                    end else begin
                        frac_d = frac_q << 1;
                        exp_d  = exp_q - EXP_W'(1);
                        cnt_d  = cnt_q + 5'd1;
                    end
                end else begin
                    state_d = ROUND;
                end
`endif
            end
            ROUND: begin
                result_d = rnd_result;
                ovf_d    = rnd_ovf;
                unf_d    = rnd_unf;
                inx_d    = rnd_inx;
                state_d  = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready      = (state_q == IDLE);
        bus.out_valid     = (state_q == OUT);
        bus.out_result    = result_q;
        bus.out_overflow  = ovf_q;
        bus.out_underflow = unf_q;
        bus.out_inexact   = inx_q;
        dbg_state         = state_q;
    end
endmodule
